cm_arb: RTL and testbench
=========================

# cm_arb

Synchronous two-input merge arbiter for the data-driven pipeline. It is the counterpart of the branch stage: two upstream Send/Ack producers, such as the two outputs of a branch or two parallel nodes, share one downstream Send/Ack stage and its data bus. Each grant runs one full four-phase return-to-zero transfer. Grants are round-robin, and a per-token capture pulse and select flag are provided for the downstream latch.

## Interface
Parameters:
- DW, 16, data token width in bits

Ports:
- CLK  in  1  single clock; all state updates on rising edge
- MR_N  in  1  master reset, asynchronous, active-low
- Send_in_a  in  1  request from producer A; synchronous to CLK
- Data_in_a  in  DW  token from A; valid while Send_in_a=1
- Ack_out_a  out  1  acknowledge to A
- Send_in_b  in  1  request from producer B
- Data_in_b  in  DW  token from B
- Ack_out_b  out  1  acknowledge to B
- Send_out  out  1  request to downstream stage
- Data_out  out  DW  registered token; stable from grant until return to IDLE
- Ack_in  in  1  acknowledge from downstream
- MG_CP  out  1  one-cycle pulse on the cycle after a grant, when Data_out is first valid
- MG_SEL  out  1  granted source: 0=A, 1=B; held for the whole transfer

## Operation
- All outputs are registered.
- Reset values, forced while MR_N=0:
  - Ack_out_a=0, Ack_out_b=0, Send_out=0
  - Data_out=0, MG_CP=0, MG_SEL=0
  - state=IDLE, last=B, so A wins the first contention
- IDLE:
  - Grant only when Ack_in=0 and (Send_in_a | Send_in_b).
  - Single requester wins.
  - If both request, the winner is the source that is not `last`.
  - On grant: Data_out<=Data_in_g, MG_SEL<=g, MG_CP<=1, Send_out<=1, go to REQ.
  - If Ack_in=1 in IDLE (stale downstream ack), no grant is made until it falls.
- REQ: hold Send_out=1. On Ack_in=1: Ack_out_g<=1, go to ACK.
- ACK: hold Send_out=1 and Ack_out_g=1. On Send_in_g=0: Send_out<=0, go to RTZ.
- RTZ: on Ack_in=0: Ack_out_g<=0, last<=g, go to IDLE.
- The non-granted Ack_out stays 0 throughout. The non-granted request stays pending and is not lost.
- Withdrawing Send_in_g before Ack_out_g is a protocol violation. The block does not abort: it stays in REQ until Ack_in and completes the transfer with the latched data.
- Data_in of the granted port is sampled once, at grant. Later changes are ignored.
- Deasserting MR_N mid-transfer: all outputs drop to reset values immediately (asynchronous). Producers and the consumer are reset by the same MR_N.

## Timing
- Grant latency: request sampled at edge N; Send_out, Data_out, MG_SEL and MG_CP are valid after edge N, visible in cycle N+1.
- Each handshake edge is answered one cycle after it is sampled:
  - Ack_in rise -> Ack_out_g rise
  - Send_in_g fall -> Send_out fall
  - Ack_in fall -> Ack_out_g fall
- Minimum period with zero-delay partners: 4 cycles per token (IDLE, REQ, ACK, RTZ).
- IDLE grants on the first cycle it is entered, so back-to-back tokens need no idle cycle.
- MG_CP is high for exactly one cycle per token.
- Under continuous dual requests, grants strictly alternate A, B, A, B.

## Structure
- Shared package ddp_hs_pkg holds:
  - state enum {IDLE, REQ, ACK, RTZ}
  - source constants SRC_A=0, SRC_B=1
  - the reset value of `last`, SRC_B
- Sub-module rr_pick2 (purely combinational):
  - inputs: req_a, req_b, last
  - outputs: gnt_valid, gnt_sel
- The FSM, the data register and the last-grant register stay in cm_arb.

## Test plan
- Reset then Send_in_a=1, Data_in_a=16'h1234, downstream acks one cycle after Send_out:
  - Data_out=16'h1234, MG_SEL=0, one MG_CP pulse
  - Ack_out_a follows the full four-phase cycle; Ack_out_b stays 0.
- After reset, Send_in_a and Send_in_b rise in the same cycle and stay high for 4 tokens:
  - grant order A, B, A, B
  - exactly 4 MG_CP pulses, 4 cycles apart
- Ack_in held high for 3 cycles before any request, then a B request arrives: no grant until the cycle after Ack_in falls.
- Data_in_b changes from 16'h00FF to 16'hFF00 one cycle after grant: Data_out stays 16'h00FF until IDLE.
- MR_N pulsed low while in ACK with Send_out=1 and Ack_out_b=1:
  - all outputs 0 within the same cycle
  - after release, the next contention is won by A.
- Send_in_a withdrawn while in REQ: Send_out stays 1 until Ack_in, then the transfer completes normally with Ack_out_a pulsing.

Source files
------------

// File: rtl/ddp_hs_pkg.sv
// rtl/ddp_hs_pkg.sv - shared Send/Ack handshake states and source constants
package ddp_hs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        RTZ  = 2'd3
    } hs_state_t;

    localparam logic SRC_A    = 1'b0;
    localparam logic SRC_B    = 1'b1;
    // B as the reset "last" source makes A win the first contention
    localparam logic LAST_RST = SRC_B;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin pick, purely combinational
module rr_pick2
    import ddp_hs_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_sel
);

    logic w_both;

    assign w_both    = req_a & req_b;
    assign gnt_valid = req_a | req_b;
    // On contention the source that did not win last time goes next
    assign gnt_sel   = w_both ? ~last : (req_b ? SRC_B : SRC_A);

endmodule

// File: rtl/cm_arb.sv
// rtl/cm_arb.sv - two-input round-robin merge arbiter, four-phase Send/Ack
module cm_arb
    import ddp_hs_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          CLK,
    input  logic          MR_N,
    input  logic          Send_in_a,
    input  logic [DW-1:0] Data_in_a,
    output logic          Ack_out_a,
    input  logic          Send_in_b,
    input  logic [DW-1:0] Data_in_b,
    output logic          Ack_out_b,
    output logic          Send_out,
    output logic [DW-1:0] Data_out,
    input  logic          Ack_in,
    output logic          MG_CP,
    output logic          MG_SEL
);

    hs_state_t     r_state;
    hs_state_t     w_next;
    logic          r_last;
    logic          r_sel;
    logic          r_cp;
    logic          r_send;
    logic          r_ack_a;
    logic          r_ack_b;
    logic [DW-1:0] r_data;

    logic          w_gnt_valid;
    logic          w_gnt_sel;
    logic          w_grant;
    logic          w_send_g;

    rr_pick2 u_pick (
        .req_a     (Send_in_a),
        .req_b     (Send_in_b),
        .last      (r_last),
        .gnt_valid (w_gnt_valid),
        .gnt_sel   (w_gnt_sel)
    );

    // A stale downstream ack blocks new grants until it has returned to zero
    assign w_grant  = (r_state == IDLE) && !Ack_in && w_gnt_valid;
    assign w_send_g = (r_sel == SRC_B) ? Send_in_b : Send_in_a;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_grant)   w_next = REQ;
            REQ:     if (Ack_in)    w_next = ACK;
            ACK:     if (!w_send_g) w_next = RTZ;
            RTZ:     if (!Ack_in)   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge MR_N) begin
        if (!MR_N) begin
            r_state <= IDLE;
            r_last  <= LAST_RST;
            r_sel   <= SRC_A;
            r_cp    <= 1'b0;
            r_send  <= 1'b0;
            r_ack_a <= 1'b0;
            r_ack_b <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            r_cp    <= w_grant;
            if (w_grant) begin
                r_data <= (w_gnt_sel == SRC_B) ? Data_in_b : Data_in_a;
                r_sel  <= w_gnt_sel;
                r_send <= 1'b1;
            end
            if (r_state == REQ && Ack_in) begin
                r_ack_a <= (r_sel == SRC_A);
                r_ack_b <= (r_sel == SRC_B);
            end
            if (r_state == ACK && !w_send_g) begin
                r_send <= 1'b0;
            end
            if (r_state == RTZ && !Ack_in) begin
                r_ack_a <= 1'b0;
                r_ack_b <= 1'b0;
                r_last  <= r_sel;
            end
        end
    end

    assign Ack_out_a = r_ack_a;
    assign Ack_out_b = r_ack_b;
    assign Send_out  = r_send;
    assign Data_out  = r_data;
    assign MG_CP     = r_cp;
    assign MG_SEL    = r_sel;

endmodule

// File: tb/tb_cm_arb.sv
// tb/tb_cm_arb.sv - directed self-checking bench for cm_arb
module tb_cm_arb;

    localparam int DW = 16;

    logic          CLK;
    logic          MR_N;
    logic          Send_in_a;
    logic [DW-1:0] Data_in_a;
    logic          Ack_out_a;
    logic          Send_in_b;
    logic [DW-1:0] Data_in_b;
    logic          Ack_out_b;
    logic          Send_out;
    logic [DW-1:0] Data_out;
    logic          Ack_in;
    logic          MG_CP;
    logic          MG_SEL;

    int n_tests;
    int n_fail;

    // partner models and observation bookkeeping
    bit  auto_cons;
    int  cnt_a;
    int  cnt_b;
    int  cyc;
    int  cp_cnt;
    int  ack_a_hi;
    int  ack_b_hi;
    int  send_hi;
    bit  chg_b_on_grant;
    int            cp_cyc[$];
    logic          cp_sel[$];
    logic [DW-1:0] cp_data[$];

    cm_arb #(.DW(DW)) dut (
        .CLK       (CLK),
        .MR_N      (MR_N),
        .Send_in_a (Send_in_a),
        .Data_in_a (Data_in_a),
        .Ack_out_a (Ack_out_a),
        .Send_in_b (Send_in_b),
        .Data_in_b (Data_in_b),
        .Ack_out_b (Ack_out_b),
        .Send_out  (Send_out),
        .Data_out  (Data_out),
        .Ack_in    (Ack_in),
        .MG_CP     (MG_CP),
        .MG_SEL    (MG_SEL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic clear_obs();
        cp_cnt = 0; ack_a_hi = 0; ack_b_hi = 0; send_hi = 0;
        cp_cyc.delete(); cp_sel.delete(); cp_data.delete();
    endtask

    // One clock: sample outputs 1 time unit after the edge, then let partners react
    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
        if (MG_CP) begin
            cp_cnt++;
            cp_cyc.push_back(cyc);
            cp_sel.push_back(MG_SEL);
            cp_data.push_back(Data_out);
            if (chg_b_on_grant) Data_in_b = 16'hFF00;
        end
        if (Ack_out_a) ack_a_hi++;
        if (Ack_out_b) ack_b_hi++;
        if (Send_out)  send_hi++;
        if (auto_cons) Ack_in = Send_out;
        if (Ack_out_a && Send_in_a) begin
            Send_in_a = 1'b0; cnt_a--;
        end else if (!Ack_out_a && !Send_in_a && cnt_a > 0) begin
            Send_in_a = 1'b1; Data_in_a = 16'hA000 | 16'(cnt_a);
        end
        if (Ack_out_b && Send_in_b) begin
            Send_in_b = 1'b0; cnt_b--;
        end else if (!Ack_out_b && !Send_in_b && cnt_b > 0) begin
            Send_in_b = 1'b1;
            if (!chg_b_on_grant) Data_in_b = 16'hB000 | 16'(cnt_b);
        end
    endtask

    task automatic do_reset();
        MR_N = 1'b0;
        Send_in_a = 0; Send_in_b = 0; Ack_in = 0;
        Data_in_a = '0; Data_in_b = '0;
        auto_cons = 0; cnt_a = 0; cnt_b = 0; chg_b_on_grant = 0;
        repeat (2) @(posedge CLK);
        #3;
        MR_N = 1'b1;
        clear_obs();
        cyc = 0;
    endtask

    task automatic test_reset();
        MR_N = 1'b0;
        Send_in_a = 1; Send_in_b = 1; Ack_in = 0;
        Data_in_a = 16'h1111; Data_in_b = 16'h2222;
        repeat (2) @(posedge CLK);
        #1;
        n_tests++;
        if ({Ack_out_a, Ack_out_b, Send_out, MG_CP, MG_SEL, Data_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b%b%b%b%b data=%h, want all 0",
                     Ack_out_a, Ack_out_b, Send_out, MG_CP, MG_SEL, Data_out);
        end
    endtask

    task automatic test_single_a();
        do_reset();
        auto_cons = 1;
        cnt_a = 1;
        Send_in_a = 1; Data_in_a = 16'h1234;
        repeat (10) step();
        n_tests++;
        if (cp_cnt !== 1) begin
            n_fail++; $display("FAIL single_cp_count: got %0d want 1", cp_cnt);
        end
        n_tests++;
        if (cp_cnt > 0 && (cp_data[0] !== 16'h1234 || cp_sel[0] !== 1'b0)) begin
            n_fail++;
            $display("FAIL single_data_sel: got %h/%b want 1234/0", cp_data[0], cp_sel[0]);
        end
        n_tests++;
        if (ack_a_hi !== 2 || ack_b_hi !== 0 || send_hi !== 2) begin
            n_fail++;
            $display("FAIL single_handshake: ack_a=%0d ack_b=%0d send=%0d want 2/0/2",
                     ack_a_hi, ack_b_hi, send_hi);
        end
        n_tests++;
        if (Ack_out_a !== 0 || Send_out !== 0 || Data_out !== 16'h1234) begin
            n_fail++;
            $display("FAIL single_final: ack_a=%b send=%b data=%h want 0/0/1234",
                     Ack_out_a, Send_out, Data_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_d [4];
        logic          exp_s [4];
        exp_d[0] = 16'hA002; exp_d[1] = 16'hB002; exp_d[2] = 16'hA001; exp_d[3] = 16'hB001;
        exp_s[0] = 0; exp_s[1] = 1; exp_s[2] = 0; exp_s[3] = 1;
        do_reset();
        auto_cons = 1;
        cnt_a = 2; cnt_b = 2;
        Send_in_a = 1; Data_in_a = 16'hA002;
        Send_in_b = 1; Data_in_b = 16'hB002;
        repeat (24) step();
        n_tests++;
        if (cp_cnt !== 4) begin
            n_fail++; $display("FAIL b2b_cp_count: got %0d want 4", cp_cnt);
        end
        for (int i = 0; i < 4 && i < cp_cnt; i++) begin
            n_tests++;
            if (cp_sel[i] !== exp_s[i] || cp_data[i] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL b2b_token%0d: sel=%b data=%h want %b/%h",
                         i, cp_sel[i], cp_data[i], exp_s[i], exp_d[i]);
            end
            if (i > 0) begin
                n_tests++;
                if (cp_cyc[i] - cp_cyc[i-1] !== 4) begin
                    n_fail++;
                    $display("FAIL b2b_gap%0d: got %0d cycles want 4", i, cp_cyc[i] - cp_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_stale_ack();
        do_reset();
        Ack_in = 1;
        repeat (3) step();
        Send_in_b = 1; Data_in_b = 16'hBEEF;
        repeat (2) step();
        n_tests++;
        if (Send_out !== 0 || cp_cnt !== 0) begin
            n_fail++;
            $display("FAIL stale_ack_block: send=%b cp=%0d want 0/0", Send_out, cp_cnt);
        end
        Ack_in = 0;
        step();
        n_tests++;
        if (Send_out !== 1 || MG_SEL !== 1 || MG_CP !== 1 || Data_out !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL stale_ack_grant: send=%b sel=%b cp=%b data=%h want 1/1/1/beef",
                     Send_out, MG_SEL, MG_CP, Data_out);
        end
        cnt_b = 1; auto_cons = 1;
        repeat (8) step();
    endtask

    task automatic test_data_hold();
        int bad;
        bad = 0;
        do_reset();
        auto_cons = 1;
        chg_b_on_grant = 1;
        cnt_b = 1;
        Send_in_b = 1; Data_in_b = 16'h00FF;
        for (int i = 0; i < 10; i++) begin
            step();
            if ((Send_out || Ack_out_b) && Data_out !== 16'h00FF) bad++;
        end
        n_tests++;
        if (bad !== 0 || cp_cnt !== 1 || Data_in_b !== 16'hFF00) begin
            n_fail++;
            $display("FAIL data_hold: bad=%0d cp=%0d data_out=%h want 0/1/00ff",
                     bad, cp_cnt, Data_out);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        do_reset();
        auto_cons = 1;
        cnt_a = 1;
        Send_in_a = 1; Data_in_a = 16'h0A0A;
        repeat (8) step();
        auto_cons = 1;
        Send_in_b = 1; Data_in_b = 16'h0B0B;
        guard = 0;
        while (!Ack_out_b && guard < 20) begin
            step();
            guard++;
        end
        n_tests++;
        if (!(Ack_out_b && Send_out)) begin
            n_fail++;
            $display("FAIL reset_mid_reach_ack: ack_b=%b send=%b want 1/1", Ack_out_b, Send_out);
        end
        #2;
        MR_N = 1'b0;
        #1;
        n_tests++;
        if ({Ack_out_a, Ack_out_b, Send_out, MG_CP, MG_SEL, Data_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %b%b%b%b%b data=%h want all 0",
                     Ack_out_a, Ack_out_b, Send_out, MG_CP, MG_SEL, Data_out);
        end
        Send_in_a = 0; Send_in_b = 0; Ack_in = 0; auto_cons = 0;
        @(posedge CLK);
        #3;
        MR_N = 1'b1;
        clear_obs();
        auto_cons = 1;
        cnt_a = 1; cnt_b = 1;
        Send_in_a = 1; Data_in_a = 16'hA001;
        Send_in_b = 1; Data_in_b = 16'hB001;
        repeat (4) step();
        n_tests++;
        if (cp_cnt < 1 || cp_sel[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_winner: cp=%0d first_sel=%b want >=1/0",
                     cp_cnt, (cp_cnt > 0) ? cp_sel[0] : 1'bx);
        end
        repeat (8) step();
    endtask

    task automatic test_withdraw();
        do_reset();
        Send_in_a = 1; Data_in_a = 16'h5555;
        step();
        Send_in_a = 0;
        repeat (2) step();
        n_tests++;
        if (Send_out !== 1 || Ack_out_a !== 0) begin
            n_fail++;
            $display("FAIL withdraw_hold: send=%b ack_a=%b want 1/0", Send_out, Ack_out_a);
        end
        Ack_in = 1;
        step();
        n_tests++;
        if (Ack_out_a !== 1 || Send_out !== 1) begin
            n_fail++;
            $display("FAIL withdraw_ack: ack_a=%b send=%b want 1/1", Ack_out_a, Send_out);
        end
        step();
        n_tests++;
        if (Send_out !== 0 || Ack_out_a !== 1) begin
            n_fail++;
            $display("FAIL withdraw_rtz: send=%b ack_a=%b want 0/1", Send_out, Ack_out_a);
        end
        Ack_in = 0;
        step();
        n_tests++;
        if (Ack_out_a !== 0 || Ack_out_b !== 0 || Data_out !== 16'h5555) begin
            n_fail++;
            $display("FAIL withdraw_done: ack_a=%b ack_b=%b data=%h want 0/0/5555",
                     Ack_out_a, Ack_out_b, Data_out);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        clear_obs();
        test_reset();
        test_single_a();
        test_back_to_back();
        test_stale_ack();
        test_data_hold();
        test_reset_mid();
        test_withdraw();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
